// File: rtl/counter_input_conditioner_pkg.sv
// counter_input_conditioner_pkg: shared FSM encoding, default timing constants and width helper
package counter_input_conditioner_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, HELD = 2'd1, RPT = 2'd2} btn_state_e;
  localparam int DEF_DEB_CYCLES = 16;
  localparam int DEF_REPEAT_FIRST = 0;
  localparam int DEF_REPEAT_PERIOD = 8;
  // never returns less than 1 so degenerate parameters still give a legal vector
  function automatic int clog2(input int v);
    int r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/counter_input_conditioner_if.sv
// counter_input_conditioner_if: raw board inputs and conditioned outputs of the conditioner
interface counter_input_conditioner_if;
  logic BTN_RAW;
  logic SW_RAW;
  logic STEP;
  logic MODE;
  logic BTN_LVL;
  modport master (output BTN_RAW, SW_RAW, input STEP, MODE, BTN_LVL);
  modport slave (input BTN_RAW, SW_RAW, output STEP, MODE, BTN_LVL);
endinterface

// File: rtl/counter_input_conditioner_debounce_channel.sv
// debounce_channel: two-flop synchroniser plus counter-based debouncer with rising-edge pulse
module debounce_channel
  import counter_input_conditioner_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic Clk,
  input  logic RST,
  input  logic raw_in,
  output logic stable_out,
  output logic rise_out
);
  localparam int W = clog2(DEB_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(DEB_CYCLES - 1);
  logic sync1, sync2;
  logic [W-1:0] cnt;
  always_ff @(posedge Clk) begin
    if (RST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      stable_out <= 1'b0;
      rise_out <= 1'b0;
      cnt <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
      rise_out <= 1'b0;
      if (sync2 == stable_out) cnt <= '0;
      else if (cnt == LAST) begin
        stable_out <= sync2;
        rise_out <= sync2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/counter_input_conditioner.sv
// counter_input_conditioner: debounced mode level and press/auto-repeat step pulses for the up/down counter
module counter_input_conditioner
  import counter_input_conditioner_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int REPEAT_FIRST = DEF_REPEAT_FIRST,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input logic Clk,
  input logic RST,
  counter_input_conditioner_if.slave bus
);
  localparam int TMAX = (REPEAT_FIRST > REPEAT_PERIOD) ? REPEAT_FIRST : REPEAT_PERIOD;
  localparam int TW = clog2(TMAX + 1);
  btn_state_e state, state_nx;
  logic [TW-1:0] tmr, tmr_nx;
  logic step, step_nx, btn_lvl, btn_rise, sw_rise_unused;
  debounce_channel #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
    .Clk(Clk), .RST(RST), .raw_in(bus.BTN_RAW), .stable_out(btn_lvl), .rise_out(btn_rise)
  );
  debounce_channel #(.DEB_CYCLES(DEB_CYCLES)) u_sw (
    .Clk(Clk), .RST(RST), .raw_in(bus.SW_RAW), .stable_out(bus.MODE), .rise_out(sw_rise_unused)
  );
  assign bus.BTN_LVL = btn_lvl;
  assign bus.STEP = step;
  // tmr counts edges since the last pulse, so a pulse fires when it equals the interval
  always_comb begin
    state_nx = state;
    tmr_nx = tmr;
    step_nx = 1'b0;
    case (state)
      IDLE: if (btn_rise) begin
        step_nx = 1'b1;
        tmr_nx = TW'(1);
        state_nx = HELD;
      end
      HELD: if (!btn_lvl) state_nx = IDLE;
        else if (REPEAT_FIRST != 0) begin
          if (tmr == TW'(REPEAT_FIRST)) begin
            step_nx = 1'b1;
            tmr_nx = TW'(1);
            state_nx = RPT;
          end else tmr_nx = tmr + 1'b1;
        end
      RPT: if (!btn_lvl) state_nx = IDLE;
        else if (tmr == TW'(REPEAT_PERIOD)) begin
          step_nx = 1'b1;
          tmr_nx = TW'(1);
        end else tmr_nx = tmr + 1'b1;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (RST) begin
      state <= IDLE;
      tmr <= '0;
      step <= 1'b0;
    end else begin
      state <= state_nx;
      tmr <= tmr_nx;
      step <= step_nx;
    end
  end
endmodule
